act_lut_ctrl: RTL and testbench
===============================

ACT_LUT_CTRL -- requirements
Module: act_lut_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element/LUT word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, LUT address width.
REQ-003 SHALL have parameter LUT_ENTRIES, default 18, which is 16 normal entries plus the overflow entry (16) and the underflow entry (17).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result buffer depth, minimum 3.
REQ-005 i_clk  in  1  sole clock; all state on rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_load_start  in  1  pulse; begin LUT table load.
REQ-008 i_load_vld / o_load_rdy  in/out  1/1  load word handshake.
REQ-009 i_load_dat  in  DATA_WIDTH  LUT word.
REQ-010 o_lut_we, o_lut_waddr, o_lut_wdat  out  1/ADDR_WIDTH/DATA_WIDTH  LUT RAM write port.
REQ-011 i_run_start, i_run_len  in  1/16  pulse plus element count for a run.
REQ-012 i_dat_vld / o_dat_rdy, i_dat  in/out, in  1/1, DATA_WIDTH  input element stream.
REQ-013 o_gen_vld, o_gen_dat  out  1/DATA_WIDTH  drive address-generator stage (1-cycle latency).
REQ-014 i_lut_rdat  in  DATA_WIDTH  LUT RAM read data, valid 2 cycles after o_gen_vld.
REQ-015 o_res_vld / i_res_rdy, o_res_dat  out/in, out  1/1, DATA_WIDTH  result stream.
REQ-016 o_busy, o_done  out  1/1  not-IDLE flag; one-cycle run-complete pulse.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, DRAIN, with IDLE as the reset state.
REQ-018 IDLE SHALL go to LOAD on i_load_start, else to RUN on i_run_start with i_run_len!=0; i_load_start SHALL take priority; i_run_len==0 SHALL be ignored.
REQ-019 Starts in any non-IDLE state SHALL be ignored.
REQ-020 In LOAD, o_load_rdy=1; each accepted word SHALL produce o_lut_we=1 the same cycle, with waddr incrementing from 0.
REQ-021 After entry LUT_ENTRIES-1 is written, the FSM SHALL return to IDLE.
REQ-022 In RUN, o_dat_rdy SHALL be 1 only when in_flight+fifo_count < FIFO_DEPTH and the accepted count < run_len.
REQ-023 Each accepted element SHALL be forwarded combinationally as o_gen_vld/o_gen_dat.
REQ-024 A 2-stage valid shift register SHALL capture i_lut_rdat into the result FIFO exactly 2 cycles after o_gen_vld; capture SHALL never be dropped.
REQ-025 Results SHALL leave in acceptance order; with i_res_rdy=1 and an empty FIFO, the first result SHALL be presented in the cycle after capture.
REQ-026 Once run_len elements are accepted, RUN SHALL go to DRAIN.
REQ-027 DRAIN SHALL go to IDLE when the pipeline and FIFO are empty and the last result is handshaken; o_done SHALL pulse in that cycle.
REQ-028 Simultaneous FIFO push and pop SHALL leave the count unchanged; full and empty SHALL both be handled without overflow or underflow.
REQ-029 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-030 On reset assertion, the FSM SHALL go to IDLE immediately; counters, FIFO pointers and pipeline valids SHALL clear.
REQ-031 The reset value of every output (o_load_rdy, o_lut_we, o_dat_rdy, o_gen_vld, o_res_vld, o_busy, o_done) SHALL be 0, including for a mid-run reset, and in-flight data SHALL be discarded.

Configuration
REQ-032 With ACT_LUT_PERF_EN defined, the block SHALL add output o_stall_cnt[15:0].
REQ-033 o_stall_cnt SHALL count RUN/DRAIN cycles with o_res_vld=1 and i_res_rdy=0, saturate at 16'hFFFF, and clear on run start and on reset.
REQ-034 Without ACT_LUT_PERF_EN, the port and counter SHALL be absent and the block otherwise identical.

Structure
REQ-035 The FSM state encoding and the LUT_ENTRIES/overflow/underflow index constants SHALL be defined in the shared package npu_act_pkg.
REQ-036 The result FIFO SHALL be one sub-module, act_res_fifo (synchronous, count-based).

Verification
REQ-037 Load 18 words 0x00..0x11 with gaps in i_load_vld: waddr 0..17 written once each, FSM back in IDLE, o_busy=0.
REQ-038 Run of 8 elements with i_res_rdy=1: 8 results in order, first result 3 cycles after the first accept, o_done pulses once.
REQ-039 Run of 10 with i_res_rdy=0 for 20 cycles: o_dat_rdy drops after 4 outstanding, no result lost, and o_stall_cnt=20 (PERF_EN).
REQ-040 i_run_start during RUN and i_run_len=0 in IDLE: both ignored, state unchanged.
REQ-041 Reset asserted mid-DRAIN with 2 results buffered: all outputs 0 at once, and a following run of 1 element completes normally.

Source files
------------

// File: rtl/npu_act_pkg.sv
// Shared FSM encoding and LUT index constants for the NPU activation LUT controller.
package npu_act_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } act_state_e;

  // 16 normal entries, then the overflow and underflow entries.
  localparam int LUT_NORMAL_ENTRIES  = 16;
  localparam int LUT_OVF_IDX         = 16;
  localparam int LUT_UDF_IDX         = 17;
  localparam int LUT_ENTRIES_DEFAULT = 18;

endpackage

// File: rtl/act_res_fifo.sv
// Synchronous count-based result FIFO; simultaneous push/pop keeps the count.
module act_res_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_push,
  input  logic [DATA_WIDTH-1:0]            i_wdat,
  input  logic                             i_pop,
  output logic [DATA_WIDTH-1:0]            o_rdat,
  output logic [$clog2(DEPTH+1)-1:0]       o_count,
  output logic                             o_empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdat;
  end

  assign o_rdat  = mem[rd_ptr];
  assign o_count = count;

endmodule

// File: rtl/act_lut_ctrl.sv
// Activation LUT controller: LUT table load, element streaming through the LUT read
// pipeline and in-order result buffering. Optional stall counter: ACT_LUT_PERF_EN.
module act_lut_ctrl
  import npu_act_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int LUT_ENTRIES = LUT_ENTRIES_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load_start,
  input  logic                  i_load_vld,
  output logic                  o_load_rdy,
  input  logic [DATA_WIDTH-1:0] i_load_dat,
  output logic                  o_lut_we,
  output logic [ADDR_WIDTH-1:0] o_lut_waddr,
  output logic [DATA_WIDTH-1:0] o_lut_wdat,
  input  logic                  i_run_start,
  input  logic [15:0]           i_run_len,
  input  logic                  i_dat_vld,
  output logic                  o_dat_rdy,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic                  o_gen_vld,
  output logic [DATA_WIDTH-1:0] o_gen_dat,
  input  logic [DATA_WIDTH-1:0] i_lut_rdat,
  output logic                  o_res_vld,
  input  logic                  i_res_rdy,
  output logic [DATA_WIDTH-1:0] o_res_dat,
  output logic                  o_busy,
  output logic                  o_done
`ifdef ACT_LUT_PERF_EN
  ,
  output logic [15:0]           o_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  act_state_e            state;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [15:0]           run_len_q, acc_cnt;
  logic                  vld_p1, vld_p2;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic [CNT_W:0]        outstanding;
  logic                  load_acc, load_last, dat_acc, acc_last, res_pop, drain_done, run_go;

  assign load_acc  = (state == ST_LOAD) && i_load_vld;
  assign load_last = (load_addr == ADDR_WIDTH'(LUT_ENTRIES - 1));
  assign run_go    = (state == ST_IDLE) && !i_load_start && i_run_start && (i_run_len != 16'd0);

  // Elements in the read pipeline plus buffered results bound further acceptance,
  // so a capture always finds a free FIFO slot.
  assign outstanding = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, vld_p1} + {{CNT_W{1'b0}}, vld_p2};

  assign o_load_rdy  = (state == ST_LOAD);
  assign o_lut_we    = load_acc;
  assign o_lut_waddr = load_addr;
  assign o_lut_wdat  = i_load_dat;

  assign o_dat_rdy = (state == ST_RUN) && (outstanding < (CNT_W+1)'(FIFO_DEPTH)) &&
                     (acc_cnt < run_len_q);
  assign dat_acc   = o_dat_rdy && i_dat_vld;
  assign acc_last  = ((acc_cnt + 16'd1) == run_len_q);
  assign o_gen_vld = dat_acc;
  assign o_gen_dat = i_dat;

  assign o_res_vld  = !fifo_empty;
  assign res_pop    = o_res_vld && i_res_rdy;
  assign drain_done = (state == ST_DRAIN) && !vld_p1 && !vld_p2 &&
                      (fifo_cnt == CNT_W'(1)) && res_pop;
  assign o_done     = drain_done;
  assign o_busy     = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      load_addr <= '0;
      run_len_q <= '0;
      acc_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_load_start) begin
            state     <= ST_LOAD;
            load_addr <= '0;
          end else if (run_go) begin
            state     <= ST_RUN;
            run_len_q <= i_run_len;
            acc_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (load_acc) begin
            if (load_last) state <= ST_IDLE;
            else           load_addr <= load_addr + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (dat_acc) begin
            acc_cnt <= acc_cnt + 16'd1;
            if (acc_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- p1/p2: address-generator stage, then LUT RAM read; capture at p2 ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= dat_acc;
      vld_p2 <= vld_p1;
    end
  end

  act_res_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_res_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (vld_p2),
    .i_wdat (i_lut_rdat),
    .i_pop  (res_pop),
    .o_rdat (o_res_dat),
    .o_count(fifo_cnt),
    .o_empty(fifo_empty)
  );

`ifdef ACT_LUT_PERF_EN
  logic [15:0] stall_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (run_go) begin
      stall_cnt <= '0;
    end else if (((state == ST_RUN) || (state == ST_DRAIN)) && o_res_vld && !i_res_rdy) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_act_lut_ctrl.sv
// Randomized bench for act_lut_ctrl with an in-bench transaction model and LUT RAM.
`timescale 1ns/1ps
module tb_act_lut_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NE = 18;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_load_start = 1'b0, i_load_vld = 1'b0;
  logic [DW-1:0] i_load_dat = '0;
  logic          i_run_start = 1'b0;
  logic [15:0]   i_run_len = '0;
  logic          i_dat_vld = 1'b0;
  logic [DW-1:0] i_dat = '0;
  logic [DW-1:0] i_lut_rdat;
  logic          i_res_rdy = 1'b0;
  logic          o_load_rdy, o_lut_we, o_dat_rdy, o_gen_vld, o_res_vld, o_busy, o_done;
  logic [AW-1:0] o_lut_waddr;
  logic [DW-1:0] o_lut_wdat, o_gen_dat, o_res_dat;
`ifdef ACT_LUT_PERF_EN
  logic [15:0]   o_stall_cnt;
`endif

  act_lut_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LUT_ENTRIES(NE), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_start(i_load_start), .i_load_vld(i_load_vld), .o_load_rdy(o_load_rdy),
    .i_load_dat(i_load_dat), .o_lut_we(o_lut_we), .o_lut_waddr(o_lut_waddr),
    .o_lut_wdat(o_lut_wdat), .i_run_start(i_run_start), .i_run_len(i_run_len),
    .i_dat_vld(i_dat_vld), .o_dat_rdy(o_dat_rdy), .i_dat(i_dat),
    .o_gen_vld(o_gen_vld), .o_gen_dat(o_gen_dat), .i_lut_rdat(i_lut_rdat),
    .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_res_dat(o_res_dat),
    .o_busy(o_busy), .o_done(o_done)
`ifdef ACT_LUT_PERF_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [4:0] lut_idx(input logic [DW-1:0] d);
    return 5'(d % NE);
  endfunction

  // Environment: address generator (1 cycle) + LUT RAM read (1 cycle).
  logic [DW-1:0] ram [NE];
  int            wr_cnt [32];
  logic          s_we = 1'b0, s_gen_vld = 1'b0, ag_vld = 1'b0;
  logic [AW-1:0] s_waddr = '0;
  logic [DW-1:0] s_wdat = '0, s_gen_dat = '0;
  logic [4:0]    ag_addr = '0;

  always @(negedge clk) begin
    s_we = o_lut_we; s_waddr = o_lut_waddr; s_wdat = o_lut_wdat;
    s_gen_vld = o_gen_vld; s_gen_dat = o_gen_dat;
  end

  always @(posedge clk) begin
    if (s_we) begin
      if (int'(s_waddr) < NE) ram[s_waddr] <= s_wdat;
      wr_cnt[s_waddr] <= wr_cnt[s_waddr] + 1;
    end
    ag_vld     <= s_gen_vld;
    ag_addr    <= lut_idx(s_gen_dat);
    i_lut_rdat <= ag_vld ? ram[ag_addr] : DW'($urandom);
  end

  // Transaction model: phase, accepted count, and pending results with the cycle
  // from which each may be presented (acceptance + 3).
  typedef struct { logic [DW-1:0] d; int rdy_cyc; } res_t;
  res_t          q[$];
  logic [DW-1:0] lut_m [NE];
  int ph = 0, ld_idx = 0, m_len = 0, m_acc = 0, cyc = 0, m_stall = 0;
  int done_seen = 0, res_cnt = 0, acc_obs = 0, first_acc = -1, first_res = -1;

  always @(negedge clk) begin
    logic e_dat_rdy, e_res_vld, hs, e_done;
    cyc++;
    if (!rst_n) begin
      q.delete(); ph = 0; m_stall = 0;
      chk("reset_outputs", 32'({o_load_rdy, o_lut_we, o_dat_rdy, o_gen_vld, o_res_vld, o_busy, o_done}), 0);
    end else begin
      e_dat_rdy = (ph == 2) && (q.size() < FD) && (m_acc < m_len);
      e_res_vld = (q.size() > 0) && (q[0].rdy_cyc <= cyc);
      hs        = e_res_vld && i_res_rdy;
      e_done    = (ph == 3) && (q.size() == 1) && hs;
      chk("ctrl", 32'({o_load_rdy, o_lut_we, o_dat_rdy, o_gen_vld, o_res_vld, o_busy, o_done}),
          32'({ph == 1, (ph == 1) && i_load_vld, e_dat_rdy, e_dat_rdy && i_dat_vld,
               e_res_vld, ph != 0, e_done}));
      if (ph == 1 && i_load_vld) begin
        chk("lut_waddr", 32'(o_lut_waddr), 32'(ld_idx));
        chk("lut_wdat", 32'(o_lut_wdat), 32'(i_load_dat));
      end
      if (e_dat_rdy && i_dat_vld) chk("gen_dat", 32'(o_gen_dat), 32'(i_dat));
      if (e_res_vld) chk("res_dat", 32'(o_res_dat), 32'(q[0].d));
`ifdef ACT_LUT_PERF_EN
      chk("stall_cnt", 32'(o_stall_cnt), 32'(m_stall));
`endif
      if (o_done) done_seen++;
      if (o_gen_vld) acc_obs++;
      if (o_res_vld && i_res_rdy) res_cnt++;

      if (hs) begin
        if (first_res < 0) first_res = cyc;
        void'(q.pop_front());
      end
      if ((ph == 2 || ph == 3) && e_res_vld && !i_res_rdy && m_stall < 65535) m_stall++;
      case (ph)
        0: if (i_load_start) begin
             ph = 1; ld_idx = 0;
           end else if (i_run_start && i_run_len != 16'd0) begin
             ph = 2; m_len = int'(i_run_len); m_acc = 0; m_stall = 0;
             first_acc = -1; first_res = -1;
           end
        1: if (i_load_vld) begin
             ld_idx++;
             if (ld_idx == NE) ph = 0;
           end
        2: if (e_dat_rdy && i_dat_vld) begin
             q.push_back('{d: lut_m[lut_idx(i_dat)], rdy_cyc: cyc + 3});
             if (first_acc < 0) first_acc = cyc;
             m_acc++;
             if (m_acc == m_len) ph = 3;
           end
        3: if (e_done) ph = 0;
        default: ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_table(input logic rand_words);
    logic [DW-1:0] w;
    i_load_start = 1'b1; tick(); i_load_start = 1'b0;
    for (int i = 0; i < NE; i++) begin
      w = rand_words ? DW'($urandom) : DW'(i);
      repeat ($urandom_range(0, 2)) tick();
      lut_m[i] = w; i_load_dat = w; i_load_vld = 1'b1;
      tick();
      i_load_vld = 1'b0;
    end
    tick();
  endtask

  task automatic start_run(input int len);
    i_run_len = 16'(len); i_run_start = 1'b1; tick(); i_run_start = 1'b0;
  endtask

  task automatic finish_run(input int vld_pct, input int rdy_pct);
    int k = 0;
    while (ph != 0 && k < 3000) begin
      i_dat_vld = ($urandom_range(0, 99) < vld_pct);
      i_dat     = DW'($urandom);
      i_res_rdy = ($urandom_range(0, 99) < rdy_pct);
      tick(); k++;
    end
    chk("run_end_in_bound", 32'(ph), 0);
    i_dat_vld = 1'b0;
  endtask

  initial begin
    int d0, r0, a0;
    for (int i = 0; i < 32; i++) wr_cnt[i] = 0;
    repeat (3) tick();
    chk("reset_busy", 32'(o_busy), 0);
    rst_n = 1'b1; tick();

    // Table load 0x00..0x11 with gaps
    load_table(1'b0);
    chk("load_idle_busy", 32'(o_busy), 0);
    for (int i = 0; i < NE; i++) begin
      chk("ram_word", 32'(ram[i]), 32'(i));
      chk("ram_wr_once", 32'(wr_cnt[i]), 1);
    end

    // Run of 8 with results always accepted
    d0 = done_seen; r0 = res_cnt;
    i_dat_vld = 1'b1; i_res_rdy = 1'b1;
    start_run(8);
    finish_run(100, 100);
    chk("run8_latency", 32'(first_res - first_acc), 3);
    chk("run8_results", 32'(res_cnt - r0), 8);
    chk("run8_done", 32'(done_seen - d0), 1);
    chk("run8_busy", 32'(o_busy), 0);

    // Run of 10 with the result side blocked for 20 presented cycles
    r0 = res_cnt; a0 = acc_obs;
    i_dat_vld = 1'b1; i_res_rdy = 1'b0;
    start_run(10);
    for (int k = 0; k < 50 && !o_res_vld; k++) begin i_dat = DW'($urandom); tick(); end
    chk("blk_res_vld", 32'(o_res_vld), 1);
    repeat (20) begin i_dat = DW'($urandom); tick(); end
    chk("blk_accepted", 32'(acc_obs - a0), 4);
    chk("blk_dat_rdy", 32'(o_dat_rdy), 0);
`ifdef ACT_LUT_PERF_EN
    chk("blk_stall_cnt", 32'(o_stall_cnt), 20);
`endif
    finish_run(100, 100);
    chk("blk_results", 32'(res_cnt - r0), 10);

    // Starts during RUN and a zero-length start in IDLE are ignored
    d0 = done_seen; r0 = res_cnt;
    i_dat_vld = 1'b1; i_res_rdy = 1'b1;
    start_run(6);
    tick();
    i_run_len = 16'd3; i_run_start = 1'b1; i_load_start = 1'b1;
    tick();
    i_run_start = 1'b0; i_load_start = 1'b0;
    chk("restart_busy", 32'(o_busy), 1);
    finish_run(100, 100);
    chk("restart_results", 32'(res_cnt - r0), 6);
    chk("restart_done", 32'(done_seen - d0), 1);
    start_run(0);
    tick();
    chk("len0_busy", 32'(o_busy), 0);
    chk("len0_load_rdy", 32'(o_load_rdy), 0);

    // Reset in DRAIN with two results buffered
    i_dat_vld = 1'b1; i_res_rdy = 1'b0;
    start_run(2);
    for (int k = 0; k < 50 && !o_res_vld; k++) tick();
    i_dat_vld = 1'b0;
    repeat (2) tick();
    chk("pre_rst_busy", 32'(o_busy), 1);
    chk("pre_rst_res_vld", 32'(o_res_vld), 1);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async_rst_outputs",
        32'({o_load_rdy, o_lut_we, o_dat_rdy, o_gen_vld, o_res_vld, o_busy, o_done}), 0);
    repeat (2) tick();
    rst_n = 1'b1; tick();
    d0 = done_seen; r0 = res_cnt;
    start_run(1);
    finish_run(100, 100);
    chk("post_rst_results", 32'(res_cnt - r0), 1);
    chk("post_rst_done", 32'(done_seen - d0), 1);

    // Randomized tables and runs
    for (int it = 0; it < 4; it++) begin
      load_table(1'b1);
      for (int r = 0; r < 5; r++) begin
        start_run(int'($urandom_range(0, 40)));
        finish_run(int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
      end
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
